// File: rtl/num_cdc_pkg.sv
// Shared types and defaults for the six-number display bundle crossing.
package num_cdc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam int NUM_CNT     = 32'sd6;
    localparam int SYNC_D_DEF  = 32'sd3;
    localparam int TIMEOUT_DEF = 32'sd1024;

    // Wait counter width: enough to hold TIMEOUT, never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with asynchronous active-high reset to 0.
module sync_bit #(
    parameter int SYNC_D = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_D-1:0] stage_r;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[SYNC_D-2:0], d};
        end
    end

    assign q = stage_r[SYNC_D-1];

endmodule

// File: rtl/num_cdc_tx.sv
// Launching side of the six-number bundle crossing: capture, hold stable,
// announce with a toggle request and wait for the synchronised toggle ack.
module num_cdc_tx
    import num_cdc_pkg::*;
#(
    parameter int NUM_W       = 3,
    parameter int SYNC_D      = SYNC_D_DEF,
    parameter bit CHANGE_ONLY = 1'b0,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             clk_sync_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [NUM_W-1:0] num_1_i,
    input  logic [NUM_W-1:0] num_2_i,
    input  logic [NUM_W-1:0] num_3_i,
    input  logic [NUM_W-1:0] num_4_i,
    input  logic [NUM_W-1:0] num_5_i,
    input  logic [NUM_W-1:0] num_6_i,
    output logic [NUM_W-1:0] hold_num_1_o,
    output logic [NUM_W-1:0] hold_num_2_o,
    output logic [NUM_W-1:0] hold_num_3_o,
    output logic [NUM_W-1:0] hold_num_4_o,
    output logic [NUM_W-1:0] hold_num_5_o,
    output logic [NUM_W-1:0] hold_num_6_o,
    output logic             req_o,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int               CNT_W   = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TO_LIM  = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t                          state_r;
    state_t                          state_nxt;
    logic [NUM_CNT-1:0][NUM_W-1:0]   num_s;
    logic [NUM_CNT-1:0][NUM_W-1:0]   hold_r;
    logic [CNT_W-1:0]                wait_cnt_r;
    logic                            req_r;
    logic                            ready_r;
    logic                            busy_r;
    logic                            timeout_r;
    logic                            ack_s;
    logic                            accept_s;
    logic                            same_s;
    logic                            load_s;
    logic                            toggle_s;
    logic                            cnt_clr_s;
    logic                            cnt_inc_s;

    sync_bit #(
        .SYNC_D (SYNC_D)
    ) u_ack_sync (
        .clk (clk_sync_i),
        .rst (rst_i),
        .d   (ack_i),
        .q   (ack_s)
    );

    assign num_s    = {num_6_i, num_5_i, num_4_i, num_3_i, num_2_i, num_1_i};
    assign same_s   = (num_s == hold_r);
    assign accept_s = valid_i && ready_r;

    // FSM state register.
    always_ff @(posedge clk_sync_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; an unchanged bundle in change-only mode needs no handshake.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !(CHANGE_ONLY && same_s)) begin
                    state_nxt = LAUNCH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LAUNCH:   state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (ack_s == req_r) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_ACK;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        load_s    = 1'b0;
        toggle_s  = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        case (state_r)
            IDLE:     load_s = accept_s;
            LAUNCH: begin
                toggle_s  = 1'b1;
                cnt_clr_s = 1'b1;
            end
            WAIT_ACK: begin
                if (ack_s != req_r) begin
                    cnt_inc_s = 1'b1;
                end else begin
                    cnt_inc_s = 1'b0;
                end
            end
            default:  load_s = 1'b0;
        endcase
    end

    // Hold registers, toggle request, wait counter and registered status flags.
    always_ff @(posedge clk_sync_i or posedge rst_i) begin
        if (rst_i) begin
            hold_r     <= '0;
            req_r      <= 1'b0;
            wait_cnt_r <= '0;
            timeout_r  <= 1'b0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            if (load_s) begin
                hold_r <= num_s;
            end
            if (toggle_s) begin
                req_r <= ~req_r;
            end
            if (cnt_clr_s) begin
                wait_cnt_r <= '0;
            end else if (cnt_inc_s && (wait_cnt_r != CNT_MAX)) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end
            // Sticky: the block keeps waiting, only reset clears the flag.
            if ((TIMEOUT != 0) && cnt_inc_s && (wait_cnt_r >= TO_LIM)) begin
                timeout_r <= 1'b1;
            end
            ready_r <= (state_nxt == IDLE);
            busy_r  <= (state_nxt != IDLE);
        end
    end

    assign hold_num_1_o = hold_r[0];
    assign hold_num_2_o = hold_r[1];
    assign hold_num_3_o = hold_r[2];
    assign hold_num_4_o = hold_r[3];
    assign hold_num_5_o = hold_r[4];
    assign hold_num_6_o = hold_r[5];
    assign req_o        = req_r;
    assign ready_o      = ready_r;
    assign busy_o       = busy_r;
    assign timeout_o    = timeout_r;

endmodule

// File: tb/tb_num_cdc_tx.sv
// Randomised bench for num_cdc_tx against an edge-timeline model of the handshake.
module tb_num_cdc_tx;

    localparam int NUM_W       = 3;
    localparam int SYNC_D      = 3;
    localparam int TIMEOUT     = 16;
    localparam bit CHANGE_ONLY = 1'b1;

    typedef logic [5:0][NUM_W-1:0] bundle_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic       ack = 1'b0;
    bundle_t    num_b = '0;
    logic       ready, req, busy, timeout;
    logic [NUM_W-1:0] h1, h2, h3, h4, h5, h6;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: expected outputs plus the edge numbers at which the handshake progresses.
    bundle_t m_hold;
    logic    m_req, m_busy, m_ready, m_timeout;
    bit      flight, ack_sched;
    int      req_edge, ack_k, next_delay;

    num_cdc_tx #(
        .NUM_W       (NUM_W),
        .SYNC_D      (SYNC_D),
        .CHANGE_ONLY (CHANGE_ONLY),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk_sync_i   (clk),
        .rst_i        (rst),
        .valid_i      (valid),
        .ready_o      (ready),
        .num_1_i      (num_b[0]),
        .num_2_i      (num_b[1]),
        .num_3_i      (num_b[2]),
        .num_4_i      (num_b[3]),
        .num_5_i      (num_b[4]),
        .num_6_i      (num_b[5]),
        .hold_num_1_o (h1),
        .hold_num_2_o (h2),
        .hold_num_3_o (h3),
        .hold_num_4_o (h4),
        .hold_num_5_o (h5),
        .hold_num_6_o (h6),
        .req_o        (req),
        .ack_i        (ack),
        .busy_o       (busy),
        .timeout_o    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bundle_t hold_all;
        hold_all = {h6, h5, h4, h3, h2, h1};
        check_eq("hold", 32'(hold_all), 32'(m_hold));
        check_eq("req", 32'(req), 32'(m_req));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("ready", 32'(ready), 32'(m_ready));
        check_eq("timeout", 32'(timeout), 32'(m_timeout));
    endtask

    function automatic bundle_t rand_bundle();
        bundle_t b;
        for (int i = 0; i < 6; i++) begin
            b[i] = NUM_W'($urandom);
        end
        return b;
    endfunction

    // One clock: drive at the falling edge, advance the model at the rising edge, compare after it.
    task automatic cycle(input logic v, input bundle_t b);
        int  n;
        bit  same;
        @(negedge clk);
        valid = v;
        num_b = b;
        n = cyc + 1;
        if (flight && ack_sched && n == ack_k) begin
            ack = ~ack;
        end
        @(posedge clk);
        cyc = n;
        if (flight) begin
            if (n == req_edge) begin
                m_req = ~m_req;
            end
            if (ack_sched && n == ack_k + SYNC_D) begin
                flight  = 1'b0;
                m_busy  = 1'b0;
                m_ready = 1'b1;
            end else if (TIMEOUT != 0 && n == req_edge + TIMEOUT) begin
                m_timeout = 1'b1;
            end
        end else begin
            if (v && m_ready) begin
                same   = (b == m_hold);
                m_hold = b;
                if (CHANGE_ONLY && same) begin
                    m_ready = 1'b1;
                end else begin
                    flight    = 1'b1;
                    req_edge  = n + 1;
                    m_busy    = 1'b1;
                    m_ready   = 1'b0;
                    ack_sched = (next_delay > 0);
                    ack_k     = req_edge + next_delay;
                end
            end else begin
                m_ready = 1'b1;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_hold", 32'({h6, h5, h4, h3, h2, h1}), 32'd0);
        check_eq("rst_req", 32'(req), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        m_hold = '0; m_req = 1'b0; m_busy = 1'b0; m_ready = 1'b0; m_timeout = 1'b0;
        flight = 1'b0; ack_sched = 1'b0;
        ack = 1'b0;
        valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (flight && guard < 64) begin
            cycle(1'b0, rand_bundle());
            guard++;
        end
        if (flight) begin
            check_eq("drain_budget", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        bundle_t b16, b7s, b150;
        b16  = {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        b7s  = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
        b150 = {3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        next_delay = 1;

        reset_pulse();
        cycle(1'b0, '0);

        // Single transfer with ack before edge 5; busy-time valids of 7s are dropped.
        next_delay = 4;
        cycle(1'b1, b16);
        while (flight) cycle(1'b1, b7s);
        next_delay = 2;
        cycle(1'b1, b7s);
        drain();

        // Change-only: identical bundle skips the handshake, a changed one launches.
        next_delay = 3;
        cycle(1'b1, b16);
        drain();
        cycle(1'b1, b16);
        cycle(1'b1, b16);
        cycle(1'b1, b150);
        drain();

        // Ack landing exactly on the last non-timeout wait cycle.
        next_delay = 13;
        cycle(1'b1, b16);
        drain();

        // No ack: timeout sets, then a late ack still completes and timeout stays.
        next_delay = 0;
        cycle(1'b1, b7s);
        repeat (22) cycle(1'b0, rand_bundle());
        ack_sched = 1'b1;
        ack_k = cyc + 2;
        drain();
        repeat (3) cycle(1'b1, b7s);

        // Reset while waiting, then a normal transfer (first post-reset valid is not ready).
        next_delay = 0;
        cycle(1'b1, b150);
        repeat (3) cycle(1'b0, '0);
        reset_pulse();
        next_delay = 3;
        cycle(1'b1, b16);
        cycle(1'b1, b16);
        drain();

        repeat (400) begin
            bundle_t rb;
            logic rv;
            rv = ($urandom_range(0, 1) == 1);
            rb = ($urandom_range(0, 3) == 0) ? m_hold : rand_bundle();
            next_delay = $urandom_range(1, 13);
            cycle(rv, rb);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/num_cdc_tx.md
Name: num_cdc_tx

Overview:
- Launching end of the six-number display bundle crossing between clock domains.
- Captures a bundle of six NUM_W-bit numbers in the clk_sync_i domain, holds it stable, and signals it with a toggle request (req_o).
- Waits for the far-side toggle acknowledge (ack_i), synchronised internally, before accepting the next bundle.
- Replaces free-running multi-bit shifting with a coherent, handshaked hand-off.

Parameters:
- NUM_W, 3, width of each number.
- SYNC_D, 3, flop depth of the ack_i synchroniser (>=2).
- CHANGE_ONLY, 0, when 1, a bundle identical to the last sent one is accepted without a handshake.
- TIMEOUT, 1024, WAIT_ACK cycles before timeout_o is set; 0 disables the timeout.

Ports:
- clk_sync_i  in  1  clock (already decided).
- rst_i  in  1  asynchronous, active-high reset (already decided).
- valid_i  in  1  bundle on num_*_i is valid this cycle.
- ready_o  out  1  block can accept a bundle.
- num_1_i..num_6_i  in  NUM_W each  numbers to send.
- hold_num_1_o..hold_num_6_o  out  NUM_W each  registered bundle driven across the domain boundary.
- req_o  out  1  toggle request; each edge announces a new stable bundle.
- ack_i  in  1  toggle acknowledge from the far domain (asynchronous).
- busy_o  out  1  handshake in flight (state != IDLE).
- timeout_o  out  1  sticky: ack wait exceeded TIMEOUT.

Behaviour:
- Reset values (asynchronous, all registers):
  - hold_num_*_o = 0, req_o = 0, timeout_o = 0, busy_o = 0.
  - ack synchroniser all 0, state IDLE.
  - ready_o = 1 from the first edge after reset release; 0 while rst_i is high.
- Acceptance: a transfer occurs at a clock edge where valid_i && ready_o. valid_i when ready_o = 0 is ignored; there is no queuing and hold registers are unchanged.
- FSM states: IDLE, LAUNCH, WAIT_ACK.
  - IDLE:
    - On accept, hold_num_*_o <= num_*_i.
    - If CHANGE_ONLY = 1 and the inputs equal the current hold values, stay in IDLE with no req toggle and ready_o staying 1.
    - Otherwise go to LAUNCH.
  - LAUNCH (1 cycle): req_o <= ~req_o; go to WAIT_ACK. The data is therefore stable at least one full cycle before the req edge.
  - WAIT_ACK:
    - When ack_s == req_o (ack_s = last synchroniser stage), go to IDLE.
    - Otherwise increment wait_cnt.
    - If TIMEOUT != 0 and wait_cnt reaches TIMEOUT-1, set timeout_o. The block keeps waiting and never re-toggles.
- ready_o is registered: 1 exactly when the next state is IDLE. busy_o is registered: 1 in LAUNCH and WAIT_ACK.
- Latency:
  - Accept at edge 0: hold outputs valid after edge 0; req_o toggles at edge 1.
  - ack_i toggling before edge k gives ack_s valid after edge k+SYNC_D-1, return to IDLE at edge k+SYNC_D, ready_o = 1 after that edge.
- wait_cnt:
  - Width $clog2(TIMEOUT+1), minimum 1.
  - Cleared on entry to WAIT_ACK and saturates; no wrap.
  - timeout_o is cleared only by rst_i.
- Early ack: an ack_s change while in IDLE/LAUNCH has no effect; only ack_s == req_o in WAIT_ACK is evaluated.
- Simultaneous acknowledge and acceptance:
  - Ack completing at the same edge where valid_i is high does not accept; ready_o was 0 that cycle.
  - The earliest next accept is the following edge.
- Reset mid-transfer: returns to the reset state immediately. The far side shares rst_i so toggle parity stays aligned.
- Outputs stay stable while busy: hold_num_*_o never change outside the IDLE accept edge.

Decomposition:
- Package num_cdc_pkg:
  - state enum (IDLE, LAUNCH, WAIT_ACK).
  - NUM_CNT = 6.
  - default constants for SYNC_D and TIMEOUT.
- Sub-module sync_bit:
  - Parameters SYNC_D; ports clk, asynchronous reset, d, q.
  - Reset 0.
  - Used for ack_i; reusable by the far-side receiver for req_o.

Test Plan:
1. Reset: assert rst_i mid-clock -> all outputs 0 immediately; ready_o = 1 one edge after release.
2. Single transfer (SYNC_D=3): nums 1,2,3,4,5,6 with valid_i at edge 0.
   - Hold outputs show 1..6 after edge 0; req_o = 1 after edge 1; busy_o = 1.
   - ack_i -> 1 before edge 5 gives ready_o = 1 after edge 8.
3. Busy drop: while in WAIT_ACK, drive valid_i with 7,7,7,7,7,7 -> hold outputs stay 1..6, req_o unchanged; after the ack completes, a new valid is accepted.
4. CHANGE_ONLY=1: resend 1..6 -> no req_o toggle, ready_o stays 1; send 1..5,0 -> req_o toggles 1->0 at accept+1.
5. Timeout (TIMEOUT=16): no ack -> timeout_o = 1 after 16 WAIT_ACK cycles, req_o unchanged; a later ack_i toggle -> returns to IDLE, timeout_o stays 1.
6. Reset during WAIT_ACK: rst_i pulse -> req_o = 0 and hold outputs 0; with ack_i = 0 the next transfer completes normally.
